isolde_xif_coproc_frontend: RTL and testbench
=============================================

Name: isolde_xif_coproc_frontend

Overview:
- Coprocessor-side endpoint of the CORE-V XIF issue, commit and result channels.
- Decodes offloaded instructions and accepts those matching one custom opcode. Accepted instructions are buffered in an in-order queue until the CPU commits or kills them.
- Committed instructions are dispatched one at a time to a local execution unit. Each one's write-back is returned on the result channel.
- Sits between the CPU's XIF port and a coprocessor datapath.

Parameters:
X_ID_WIDTH, 4, width of the instruction id
X_NUM_RS, 2, number of source operands
X_RFR_WIDTH, 32, width of each source operand
DEPTH, 4, queue entries (power of two, at least 2)
OPCODE, 7'h0B, major opcode accepted (custom-0)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, synchronous, active-low
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue request ready
issue_instr_i  in  32  offloaded instruction
issue_id_i  in  X_ID_WIDTH  instruction id
issue_rs_i  in  X_NUM_RS*X_RFR_WIDTH  source operands, rs[0] in the LSBs
issue_rs_valid_i  in  X_NUM_RS  operand valid flags
issue_accept_o  out  1  instruction accepted
issue_writeback_o  out  1  accepted instruction will write rd
commit_valid_i  in  1  commit strobe
commit_id_i  in  X_ID_WIDTH  id being committed
commit_kill_i  in  1  kill instead of commit
exec_valid_o  out  1  dispatch to execution unit
exec_ready_i  in  1  execution unit takes the dispatch
exec_instr_o  out  32  dispatched instruction
exec_rs_o  out  X_NUM_RS*X_RFR_WIDTH  dispatched operands
exec_done_i  in  1  execution complete (single-cycle strobe)
exec_data_i  in  32  execution result
result_valid_o  out  1  result valid
result_ready_i  in  1  CPU takes the result
result_id_o  out  X_ID_WIDTH  result id
result_data_o  out  32  write-back data
result_rd_o  out  5  destination register, instr[11:7]
result_we_o  out  1  register write enable

Behaviour:
Issue decode (combinational from inputs):
- match = issue_instr_i[6:0]==OPCODE.
- Match case: issue_ready_o = !full && (&issue_rs_valid_i).
- Non-match case: issue_ready_o = 1.
- issue_accept_o = issue_writeback_o = match. Both are meaningful only while issue_valid_i is high.
- Handshake issue_valid_i && issue_ready_o with match pushes an entry at wr_ptr: {instr, id, rs, committed=0, killed=0}. A rejected instruction pushes nothing.

Queue:
- Circular, wr_ptr/rd_ptr of width log2(DEPTH) plus a count. Pointers wrap modulo DEPTH.
- full = (count==DEPTH). A push while full is impossible because ready is low.
- Push and pop in the same cycle leave count unchanged.

Commit:
- On commit_valid_i, the first valid, uncommitted entry whose id equals commit_id_i gets committed=1. killed is set to commit_kill_i.
- If no entry matches, the commit is ignored.
- A commit arriving in the same cycle as the push of that id applies to the newly pushed entry.

Dispatch FSM (registered; states IDLE, EXEC, WAIT, RESP):
- IDLE, head valid, committed and killed: pop the head, no output activity, 1 cycle per killed entry, stay IDLE.
- IDLE, head valid, committed and not killed: go to EXEC next cycle.
- EXEC: exec_valid_o=1, exec_instr_o/exec_rs_o taken from the head. On exec_ready_i go to WAIT. The outputs hold stable while waiting for ready.
- WAIT: on exec_done_i, register exec_data_i, go to RESP.
- RESP: result_valid_o=1, result_id_o = head id, result_rd_o = head instr[11:7], result_we_o=1, result_data_o = captured data. On result_ready_i, pop the head and go to IDLE.

Timing:
- A result is never returned before its commit.
- Results are returned in issue order.
- Minimum latency is 4 cycles from the commit cycle to result_valid_o, with exec_ready_i and exec_done_i responding immediately.

Reset:
- On rst_ni low at a clock edge: queue emptied, pointers and count = 0, FSM = IDLE, captured data = 0.
- exec_valid_o=0, result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0.
- Reset mid-operation discards all entries and any in-flight result.

Out of scope:
- A commit for an entry already committed or already dispatched is ignored.
- Duplicate ids live in the queue are a CPU protocol violation and are not checked.

Test Plan:
- Issue instr 0x0000_508B, id 3, rs={5,7}, all rs valid; then commit id 3, kill 0; exec unit returns 0xC one cycle after exec_ready -> accept=1, writeback=1; result_valid_o with id 3, rd 1, data 0xC, we 1.
- Issue instr 0x0000_0033 (OP opcode) -> issue_ready_o=1, accept=0, count unchanged, no exec activity.
- Fill 4 entries, ids 0..3, then present id 4 -> issue_ready_o=0. Commit id 0 and complete it -> ready returns 1 the cycle after the pop.
- Issue ids 1, 2; commit id 1 with kill; commit id 2 -> id 1 dropped with no exec_valid_o; only id 2 appears on the result channel.
- Commit id 5 in the same cycle as the issue of id 5 -> entry is committed and dispatches without a further commit.
- Hold result_ready_i=0 for 3 cycles, then assert rst_ni=0 -> result_valid_o=0 and count=0 after the edge. A new issue afterwards proceeds normally.

Source files
------------

// File: rtl/isolde_xif_coproc_frontend.sv
// Coprocessor-side XIF endpoint: decodes offloaded instructions, queues
// accepted ones in issue order until commit/kill, then dispatches committed
// ones one at a time to a local execution unit and returns the write-back.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a committed head; killed heads are dropped here
// EXEC   | presenting the head to the execution unit until it is taken
// WAIT   | execution unit busy, waiting for its done strobe
// RESP   | presenting the result to the CPU; head popped on acceptance
module isolde_xif_coproc_frontend #(
   parameter int unsigned X_ID_WIDTH  = 4,
   parameter int unsigned X_NUM_RS    = 2,
   parameter int unsigned X_RFR_WIDTH = 32,
   parameter int unsigned DEPTH       = 4,
   parameter logic [6:0]  OPCODE      = 7'h0B
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            issue_valid_i,
   output logic                            issue_ready_o,
   input  logic [31:0]                     issue_instr_i,
   input  logic [X_ID_WIDTH-1:0]           issue_id_i,
   input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_i,
   input  logic [X_NUM_RS-1:0]             issue_rs_valid_i,
   output logic                            issue_accept_o,
   output logic                            issue_writeback_o,
   input  logic                            commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]           commit_id_i,
   input  logic                            commit_kill_i,
   output logic                            exec_valid_o,
   input  logic                            exec_ready_i,
   output logic [31:0]                     exec_instr_o,
   output logic [X_NUM_RS*X_RFR_WIDTH-1:0] exec_rs_o,
   input  logic                            exec_done_i,
   input  logic [31:0]                     exec_data_i,
   output logic                            result_valid_o,
   input  logic                            result_ready_i,
   output logic [X_ID_WIDTH-1:0]           result_id_o,
   output logic [31:0]                     result_data_o,
   output logic [4:0]                      result_rd_o,
   output logic                            result_we_o
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned RSW = X_NUM_RS * X_RFR_WIDTH;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_e;

   state_e state_q, state_d;

   logic [31:0]           q_instr [DEPTH];
   logic [X_ID_WIDTH-1:0] q_id    [DEPTH];
   logic [RSW-1:0]        q_rs    [DEPTH];
   logic [DEPTH-1:0]      q_vld, q_cmt, q_kill;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic [31:0]   data_q;

   logic          match, full, push, pop;
   logic          head_vld, head_cmt, head_kill;
   logic          cmt_hit, cmt_new;
   logic [PW-1:0] cmt_idx, scan_idx;

   assign match     = (issue_instr_i[6:0] == OPCODE);
   assign full      = (count == FULL_CNT);
   assign head_vld  = q_vld[rd_ptr];
   assign head_cmt  = q_cmt[rd_ptr];
   assign head_kill = q_kill[rd_ptr];

   // Issue decode: non-matching instructions are rejected without stalling.
   always_comb begin
      issue_ready_o     = match ? (!full && (&issue_rs_valid_i)) : 1'b1;
      issue_accept_o    = match;
      issue_writeback_o = match;
      push              = issue_valid_i && issue_ready_o && match;
   end

   // Commit lookup: oldest live, still-uncommitted entry carrying the id.
   // An id being pushed this cycle is the youngest, so it only wins if no
   // queued entry matches.
   always_comb begin
      cmt_hit  = 1'b0;
      cmt_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_ptr + PW'(k);
         if (!cmt_hit && q_vld[scan_idx] && !q_cmt[scan_idx] &&
             (q_id[scan_idx] == commit_id_i)) begin
            cmt_hit = 1'b1;
            cmt_idx = scan_idx;
         end
      end
      cmt_new = commit_valid_i && !cmt_hit && push && (issue_id_i == commit_id_i);
   end

   // Queue storage, pointers, occupancy and captured execution result.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         q_vld  <= '0;
         q_cmt  <= '0;
         q_kill <= '0;
         data_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_id[i]    <= '0;
            q_rs[i]    <= '0;
         end
      end else begin
         if (push) begin
            q_instr[wr_ptr] <= issue_instr_i;
            q_id[wr_ptr]    <= issue_id_i;
            q_rs[wr_ptr]    <= issue_rs_i;
            q_vld[wr_ptr]   <= 1'b1;
            q_cmt[wr_ptr]   <= cmt_new;
            q_kill[wr_ptr]  <= cmt_new && commit_kill_i;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (commit_valid_i && cmt_hit) begin
            q_cmt[cmt_idx]  <= 1'b1;
            q_kill[cmt_idx] <= commit_kill_i;
         end
         // pop only ever targets a committed entry, commit only an
         // uncommitted one, so the two never hit the same slot
         if (pop) begin
            q_vld[rd_ptr]  <= 1'b0;
            q_cmt[rd_ptr]  <= 1'b0;
            q_kill[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (state_q == S_WAIT && exec_done_i) begin
            data_q <= exec_data_i;
         end
      end
   end

   // Dispatch FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Dispatch FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (head_vld && head_cmt && !head_kill) state_d = S_EXEC;
         S_EXEC: if (exec_ready_i)   state_d = S_WAIT;
         S_WAIT: if (exec_done_i)    state_d = S_RESP;
         S_RESP: if (result_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Dispatch FSM outputs; all result fields read zero outside RESP.
   always_comb begin
      exec_valid_o   = 1'b0;
      exec_instr_o   = '0;
      exec_rs_o      = '0;
      result_valid_o = 1'b0;
      result_id_o    = '0;
      result_data_o  = '0;
      result_rd_o    = '0;
      result_we_o    = 1'b0;
      pop            = 1'b0;
      case (state_q)
         S_IDLE: pop = head_vld && head_cmt && head_kill;
         S_EXEC: begin
            exec_valid_o = 1'b1;
            exec_instr_o = q_instr[rd_ptr];
            exec_rs_o    = q_rs[rd_ptr];
         end
         S_RESP: begin
            result_valid_o = 1'b1;
            result_id_o    = q_id[rd_ptr];
            result_data_o  = data_q;
            result_rd_o    = q_instr[rd_ptr][11:7];
            result_we_o    = 1'b1;
            pop            = result_ready_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_isolde_xif_coproc_frontend.sv
// Directed bench for the XIF coprocessor front end.
module tb_isolde_xif_coproc_frontend;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        issue_valid_i = 1'b0;
   logic        issue_ready_o;
   logic [31:0] issue_instr_i = '0;
   logic [3:0]  issue_id_i = '0;
   logic [63:0] issue_rs_i = '0;
   logic [1:0]  issue_rs_valid_i = '0;
   logic        issue_accept_o;
   logic        issue_writeback_o;
   logic        commit_valid_i = 1'b0;
   logic [3:0]  commit_id_i = '0;
   logic        commit_kill_i = 1'b0;
   logic        exec_valid_o;
   logic        exec_ready_i = 1'b0;
   logic [31:0] exec_instr_o;
   logic [63:0] exec_rs_o;
   logic        exec_done_i = 1'b0;
   logic [31:0] exec_data_i = '0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b0;
   logic [3:0]  result_id_o;
   logic [31:0] result_data_o;
   logic [4:0]  result_rd_o;
   logic        result_we_o;

   int n_tests = 0;
   int n_fail  = 0;

   isolde_xif_coproc_frontend dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
      .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
      .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
      .commit_kill_i(commit_kill_i),
      .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i),
      .exec_instr_o(exec_instr_o), .exec_rs_o(exec_rs_o),
      .exec_done_i(exec_done_i), .exec_data_i(exec_data_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_data_o(result_data_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                              input logic [31:0] rs0, input logic [31:0] rs1);
      issue_valid_i    = 1'b1;
      issue_instr_i    = instr;
      issue_id_i       = id;
      issue_rs_i       = {rs1, rs0};
      issue_rs_valid_i = 2'b11;
   endtask

   // Drive one already-committed head through exec and result channels.
   task automatic run_one(input logic [3:0] id, input logic [31:0] data,
                          input logic [4:0] rd, input bit chk_full);
      int n = 0;
      while (!exec_valid_o && n < 20) begin
         step();
         n++;
      end
      check("exec_valid_seen", exec_valid_o, 1);
      exec_ready_i = 1'b1;
      step();
      exec_ready_i = 1'b0;
      exec_done_i  = 1'b1;
      exec_data_i  = data;
      step();
      exec_done_i  = 1'b0;
      check("res_valid", result_valid_o, 1);
      check("res_id", result_id_o, id);
      check("res_rd", result_rd_o, rd);
      check("res_data", result_data_o, data);
      check("res_we", result_we_o, 1);
      if (chk_full) check("ready_before_pop", issue_ready_o, 0);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      check("res_valid_dropped", result_valid_o, 0);
      if (chk_full) check("ready_after_pop", issue_ready_o, 1);
   endtask

   initial begin
      step();
      step();
      // reset state
      check("rst_exec_valid", exec_valid_o, 0);
      check("rst_res_valid", result_valid_o, 0);
      check("rst_res_id", result_id_o, 0);
      check("rst_res_data", result_data_o, 0);
      check("rst_res_rd", result_rd_o, 0);
      check("rst_res_we", result_we_o, 0);
      check("rst_count", dut.count, 0);
      rst_ni = 1'b1;
      step();

      // basic issue / commit / execute / result
      drive_issue(32'h0000_508B, 4'd3, 32'd5, 32'd7);
      #1;
      check("t1_ready", issue_ready_o, 1);
      check("t1_accept", issue_accept_o, 1);
      check("t1_wb", issue_writeback_o, 1);
      step();
      issue_valid_i = 1'b0;
      check("t1_count", dut.count, 1);
      check("t1_no_exec_precommit", exec_valid_o, 0);
      commit_valid_i = 1'b1; commit_id_i = 4'd3; commit_kill_i = 1'b0;
      step();
      commit_valid_i = 1'b0;
      check("t1_idle_after_commit", exec_valid_o, 0);
      step();
      check("t1_exec_valid", exec_valid_o, 1);
      check("t1_exec_instr", exec_instr_o, 32'h0000_508B);
      check("t1_exec_rs", exec_rs_o, {32'd7, 32'd5});
      step();
      check("t1_exec_hold", exec_valid_o, 1);
      check("t1_exec_instr_hold", exec_instr_o, 32'h0000_508B);
      exec_ready_i = 1'b1;
      step();
      exec_ready_i = 1'b0;
      check("t1_exec_released", exec_valid_o, 0);
      exec_done_i = 1'b1; exec_data_i = 32'hC;
      step();
      exec_done_i = 1'b0;
      check("t1_res_valid", result_valid_o, 1);
      check("t1_res_id", result_id_o, 3);
      check("t1_res_rd", result_rd_o, 1);
      check("t1_res_data", result_data_o, 32'hC);
      check("t1_res_we", result_we_o, 1);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      check("t1_res_done", result_valid_o, 0);
      check("t1_count_empty", dut.count, 0);

      // non-matching opcode is rejected without a push
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_0033; issue_id_i = 4'd9;
      issue_rs_valid_i = 2'b00;
      #1;
      check("t2_ready", issue_ready_o, 1);
      check("t2_accept", issue_accept_o, 0);
      check("t2_wb", issue_writeback_o, 0);
      step();
      issue_valid_i = 1'b0;
      check("t2_count", dut.count, 0);
      step();
      check("t2_no_exec", exec_valid_o, 0);

      // matching opcode with an operand not yet valid stalls
      issue_instr_i = 32'h0000_508B; issue_rs_valid_i = 2'b01;
      #1;
      check("t2_rs_not_valid", issue_ready_o, 0);

      // fill the queue, then full back-pressure
      for (int i = 0; i < 4; i++) begin
         drive_issue(32'h0000_508B, 4'(i), 32'(i), 32'(i + 10));
         step();
      end
      issue_valid_i = 1'b0;
      check("t3_count_full", dut.count, 4);
      drive_issue(32'h0000_508B, 4'd4, 32'd0, 32'd0);
      #1;
      check("t3_full_ready", issue_ready_o, 0);
      step();
      issue_valid_i = 1'b0;
      check("t3_count_still_full", dut.count, 4);
      commit_valid_i = 1'b1; commit_id_i = 4'd0; commit_kill_i = 1'b0;
      step();
      commit_valid_i = 1'b0;
      run_one(4'd0, 32'h10, 5'd1, 1'b1);
      // kill the remaining three back to back: no exec activity allowed
      for (int i = 1; i < 4; i++) begin
         commit_valid_i = 1'b1; commit_id_i = 4'(i); commit_kill_i = 1'b1;
         step();
         check("t3_kill_no_exec", exec_valid_o, 0);
      end
      commit_valid_i = 1'b0; commit_kill_i = 1'b0;
      step();
      step();
      check("t3_drained", dut.count, 0);
      check("t3_kill_no_result", result_valid_o, 0);

      // kill id 1, commit id 2; only id 2 executes, 4-cycle latency
      drive_issue(32'h0000_508B, 4'd1, 32'd1, 32'd1);
      step();
      drive_issue(32'h0000_010B, 4'd2, 32'd2, 32'd3);
      step();
      issue_valid_i = 1'b0;
      commit_valid_i = 1'b1; commit_id_i = 4'd1; commit_kill_i = 1'b1;
      step();
      commit_id_i = 4'd2; commit_kill_i = 1'b0;
      check("t4_killed_no_exec", exec_valid_o, 0);
      step();
      commit_valid_i = 1'b0;
      check("t4_idle", exec_valid_o, 0);
      check("t4_count_after_drop", dut.count, 1);
      step();
      check("t4_exec_valid", exec_valid_o, 1);
      check("t4_exec_instr", exec_instr_o, 32'h0000_010B);
      exec_ready_i = 1'b1;
      step();
      exec_ready_i = 1'b0;
      exec_done_i = 1'b1; exec_data_i = 32'h55;
      step();
      exec_done_i = 1'b0;
      check("t4_res_valid_lat4", result_valid_o, 1);
      check("t4_res_id", result_id_o, 2);
      check("t4_res_rd", result_rd_o, 2);
      check("t4_res_data", result_data_o, 32'h55);
      result_ready_i = 1'b1;
      step();
      result_ready_i = 1'b0;
      check("t4_empty", dut.count, 0);

      // commit in the same cycle as issue
      drive_issue(32'h0000_508B, 4'd5, 32'd8, 32'd9);
      commit_valid_i = 1'b1; commit_id_i = 4'd5; commit_kill_i = 1'b0;
      step();
      issue_valid_i = 1'b0; commit_valid_i = 1'b0;
      check("t5_count", dut.count, 1);
      run_one(4'd5, 32'h77, 5'd1, 1'b0);

      // reset while a result is stalled
      drive_issue(32'h0000_508B, 4'd6, 32'd1, 32'd2);
      step();
      issue_valid_i = 1'b0;
      commit_valid_i = 1'b1; commit_id_i = 4'd6;
      step();
      commit_valid_i = 1'b0;
      step();
      exec_ready_i = 1'b1;
      step();
      exec_ready_i = 1'b0;
      exec_done_i = 1'b1; exec_data_i = 32'h66;
      step();
      exec_done_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t6_res_stalled", result_valid_o, 1);
         step();
      end
      rst_ni = 1'b0;
      step();
      check("t6_rst_res_valid", result_valid_o, 0);
      check("t6_rst_count", dut.count, 0);
      check("t6_rst_res_data", result_data_o, 0);
      check("t6_rst_res_id", result_id_o, 0);
      rst_ni = 1'b1;
      step();
      drive_issue(32'h0000_508B, 4'd7, 32'd3, 32'd4);
      step();
      issue_valid_i = 1'b0;
      commit_valid_i = 1'b1; commit_id_i = 4'd7;
      step();
      commit_valid_i = 1'b0;
      run_one(4'd7, 32'h99, 5'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
